term_ctrl: RTL and testbench



---
 rtl/term_pkg.sv | 25 ++
 rtl/term_if.sv | 30 +++
 rtl/term_cursor.sv | 59 +++++
 rtl/term_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_term_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/term_pkg.sv
// Shared definitions for the character terminal controller: FSM states,
// control codes and the printable code range.
package term_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        SCR_RD,
        SCR_WR,
        SCR_CLR,
        CLR
    } state_t;

    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;
    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] FF       = 8'h0C;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= PRINT_LO) && (code <= PRINT_HI);
    endfunction

endpackage

// File: rtl/term_if.sv
// Character input handshake, VRAM port and cursor outputs of the terminal
// controller. The controller uses the slave view; the character source and
// VRAM model use the master view.
interface term_if #(
    parameter int COL_W = 6,
    parameter int ROW_W = 5
);
    logic                   i_valid;
    logic [7:0]             i_char;
    logic                   o_ready;
    logic [ROW_W+COL_W-1:0] o_vram_addr;
    logic                   o_vram_ce;
    logic                   o_vram_we;
    logic [7:0]             o_vram_din;
    logic [7:0]             i_vram_dout;
    logic [ROW_W-1:0]       o_row;
    logic [COL_W-1:0]       o_col;

    modport master (
        output i_valid, i_char, i_vram_dout,
        input  o_ready, o_vram_addr, o_vram_ce, o_vram_we, o_vram_din,
               o_row, o_col
    );

    modport slave (
        input  i_valid, i_char, i_vram_dout,
        output o_ready, o_vram_addr, o_vram_ce, o_vram_we, o_vram_din,
               o_row, o_col
    );
endinterface

// File: rtl/term_cursor.sv
// Cursor position register: advance with wrap, line feed, carriage return,
// backspace and home. The scroll flag tells the controller that the command
// presented this cycle pushes the cursor past the last row, in which case
// the row stays on the last line and the screen contents move instead.
module term_cursor
    import term_pkg::*;
#(
    parameter int COLS  = 60,
    parameter int ROWS  = 17,
    parameter int COL_W = 6,
    parameter int ROW_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             lf,
    input  logic             cr,
    input  logic             bs,
    input  logic             home,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             scroll
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic col_last;
    logic row_last;

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign scroll   = (adv && col_last && row_last) || (lf && row_last);

    // Cursor update; commands are mutually exclusive, home wins if not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (home) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col_last) begin
                col <= '0;
                if (!row_last) row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end else if (lf) begin
            if (!row_last) row <= row + ROW_W'(1);
        end else if (cr) begin
            col <= '0;
        end else if (bs) begin
            if (col != '0) col <= col - COL_W'(1);
        end
    end

endmodule

// File: rtl/term_ctrl.sv
// Character terminal controller: accepts one character at a time, writes
// printable codes into VRAM at the cursor, interprets CR/LF/BS/FF, scrolls
// the screen up one line by VRAM read/write copy, and clears the screen.
//
// state   | meaning
// IDLE    | ready for a character (after reset may launch CLR first)
// PUT     | write latched character at cursor, advance cursor
// SCR_RD  | read cell one row below the scroll destination
// SCR_WR  | write the read data to the destination cell
// SCR_CLR | blank the last row after the copy
// CLR     | blank every cell row-major, home cursor at the end
module term_ctrl
    import term_pkg::*;
#(
    parameter int         COLS           = 60,
    parameter int         ROWS           = 17,
    parameter int         COL_W          = 6,
    parameter int         ROW_W          = 5,
    parameter logic [7:0] BLANK          = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    term_if.slave bus
);

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] SCR_ROW_LAST = ROW_W'(ROWS - 2);

    state_t           state;
    state_t           state_n;
    logic             alive;
    logic [7:0]       char_q;
    logic [ROW_W-1:0] scan_row;
    logic [ROW_W-1:0] scan_row_n;
    logic [COL_W-1:0] scan_col;
    logic [COL_W-1:0] scan_col_n;
    logic             accept;

    logic             cur_adv;
    logic             cur_lf;
    logic             cur_cr;
    logic             cur_bs;
    logic             cur_home;
    logic             cur_scroll;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;

    logic                   vram_ce;
    logic                   vram_we;
    logic [ROW_W+COL_W-1:0] vram_addr;
    logic [7:0]             vram_din;

    // alive separates the reset-held IDLE (not ready) from the normal IDLE.
    assign bus.o_ready = alive && (state == IDLE);
    assign accept      = bus.o_ready && bus.i_valid;

    term_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cursor (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .adv    (cur_adv),
        .lf     (cur_lf),
        .cr     (cur_cr),
        .bs     (cur_bs),
        .home   (cur_home),
        .row    (cur_row),
        .col    (cur_col),
        .scroll (cur_scroll)
    );

    // State, scan counters and the latched character.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            alive    <= 1'b0;
            char_q   <= '0;
            scan_row <= '0;
            scan_col <= '0;
        end else begin
            state    <= state_n;
            alive    <= 1'b1;
            scan_row <= scan_row_n;
            scan_col <= scan_col_n;
            if (accept) char_q <= bus.i_char;
        end
    end

    // Next state, cursor commands and VRAM access. Scan counters always end
    // an operation at zero so the next scroll or clear starts from (0,0).
    always_comb begin
        state_n    = state;
        scan_row_n = scan_row;
        scan_col_n = scan_col;
        vram_ce    = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_din   = '0;
        cur_adv    = 1'b0;
        cur_lf     = 1'b0;
        cur_cr     = 1'b0;
        cur_bs     = 1'b0;
        cur_home   = 1'b0;

        case (state)
            IDLE: begin
                if (!alive) begin
                    if (CLEAR_ON_RESET) state_n = CLR;
                end else if (bus.i_valid) begin
                    if (is_printable(bus.i_char)) begin
                        state_n = PUT;
                    end else begin
                        case (bus.i_char)
                            CR: cur_cr = 1'b1;
                            LF: begin
                                cur_lf = 1'b1;
                                if (cur_scroll) state_n = SCR_RD;
                            end
                            BS: cur_bs = 1'b1;
                            FF: state_n = CLR;
                            default: ;
                        endcase
                    end
                end
            end

            PUT: begin
                vram_ce   = 1'b1;
                vram_we   = 1'b1;
                vram_addr = {cur_row, cur_col};
                vram_din  = char_q;
                cur_adv   = 1'b1;
                state_n   = cur_scroll ? SCR_RD : IDLE;
            end

            SCR_RD: begin
                vram_ce   = 1'b1;
                vram_addr = {scan_row + ROW_W'(1), scan_col};
                state_n   = SCR_WR;
            end

            SCR_WR: begin
                vram_ce   = 1'b1;
                vram_we   = 1'b1;
                vram_addr = {scan_row, scan_col};
                vram_din  = bus.i_vram_dout;
                state_n   = SCR_RD;
                if (scan_col == COL_LAST) begin
                    scan_col_n = '0;
                    if (scan_row == SCR_ROW_LAST) begin
                        scan_row_n = '0;
                        state_n    = SCR_CLR;
                    end else begin
                        scan_row_n = scan_row + ROW_W'(1);
                    end
                end else begin
                    scan_col_n = scan_col + COL_W'(1);
                end
            end

            SCR_CLR: begin
                vram_ce   = 1'b1;
                vram_we   = 1'b1;
                vram_addr = {ROW_LAST, scan_col};
                vram_din  = BLANK;
                if (scan_col == COL_LAST) begin
                    scan_col_n = '0;
                    state_n    = IDLE;
                end else begin
                    scan_col_n = scan_col + COL_W'(1);
                end
            end

            CLR: begin
                vram_ce   = 1'b1;
                vram_we   = 1'b1;
                vram_addr = {scan_row, scan_col};
                vram_din  = BLANK;
                if (scan_col == COL_LAST) begin
                    scan_col_n = '0;
                    if (scan_row == ROW_LAST) begin
                        scan_row_n = '0;
                        cur_home   = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        scan_row_n = scan_row + ROW_W'(1);
                    end
                end else begin
                    scan_col_n = scan_col + COL_W'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign bus.o_vram_ce   = vram_ce;
    assign bus.o_vram_we   = vram_we;
    assign bus.o_vram_addr = vram_addr;
    assign bus.o_vram_din  = vram_din;
    assign bus.o_row       = cur_row;
    assign bus.o_col       = cur_col;

endmodule

// File: tb/tb_term_ctrl.sv
// Testbench for term_ctrl: drives characters, models VRAM as a synchronous
// RAM and keeps a screen/cursor reference model computed from the terminal
// rules (print, wrap, scroll, CR, LF, BS, FF).
`timescale 1ns/1ps
module tb_term_ctrl;

    localparam int COLS       = 60;
    localparam int ROWS       = 17;
    localparam int COL_W      = 6;
    localparam int ROW_W      = 5;
    localparam int SCROLL_CYC = 2 * COLS * (ROWS - 1) + COLS;
    localparam int CLR_CYC    = COLS * ROWS;
    localparam int TMO        = 5000;
    localparam logic [7:0] BLANK = 8'h20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #42 clk = ~clk;

    term_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    term_ctrl #(
        .COLS (COLS), .ROWS (ROWS), .COL_W (COL_W), .ROW_W (ROW_W),
        .BLANK (BLANK), .CLEAR_ON_RESET (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // VRAM model and access counters
    logic [7:0] vram [0:(1 << (ROW_W + COL_W)) - 1];
    logic seeded = 1'b0;
    int n_acc = 0, n_wr = 0, n_blank_wr = 0, n_illegal = 0;

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < (1 << (ROW_W + COL_W)); i++) vram[i] <= 8'($urandom);
            seeded <= 1'b1;
        end
        if (bus.o_vram_ce) begin
            n_acc <= n_acc + 1;
            if (int'(bus.o_vram_addr[COL_W-1:0]) >= COLS ||
                int'(bus.o_vram_addr[ROW_W+COL_W-1:COL_W]) >= ROWS)
                n_illegal <= n_illegal + 1;
            if (bus.o_vram_we) begin
                vram[bus.o_vram_addr] <= bus.o_vram_din;
                n_wr <= n_wr + 1;
                if (bus.o_vram_din == BLANK) n_blank_wr <= n_blank_wr + 1;
            end else begin
                bus.i_vram_dout <= vram[bus.o_vram_addr];
            end
        end
    end

    // Reference model
    logic [7:0] scr [ROWS][COLS];
    int m_row = 0, m_col = 0;

    function automatic int addr_of(input int r, input int c);
        return r * (1 << COL_W) + c;
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    endfunction

    function automatic void m_scroll();
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
    endfunction

    // Applies one character to the model; returns cycles o_ready stays low.
    function automatic int m_apply(input logic [7:0] ch);
        int busy = 0;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[m_row][m_col] = ch;
            busy = 1;
            if (m_col == COLS - 1) begin
                m_col = 0;
                if (m_row == ROWS - 1) begin
                    m_scroll();
                    busy += SCROLL_CYC;
                end else m_row++;
            end else m_col++;
        end else if (ch == 8'h0D) begin
            m_col = 0;
        end else if (ch == 8'h0A) begin
            if (m_row == ROWS - 1) begin
                m_scroll();
                busy = SCROLL_CYC;
            end else m_row++;
        end else if (ch == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (ch == 8'h0C) begin
            m_clear();
            m_row = 0;
            m_col = 0;
            busy = CLR_CYC;
        end
        return busy;
    endfunction

    function automatic int screen_diffs();
        int d = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (vram[addr_of(r, c)] !== scr[r][c]) d++;
        return d;
    endfunction

    // Offers one character, returns the number of cycles o_ready stayed low.
    task automatic send(input logic [7:0] ch, output int busy);
        int waitc = 0;
        @(negedge clk);
        while (!bus.o_ready && waitc < TMO) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.o_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_ready_timeout: o_ready=%b required 1", bus.o_ready);
        end
        bus.i_valid = 1'b1;
        bus.i_char  = ch;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        busy = 0;
        while (!bus.o_ready && busy < TMO) begin
            @(posedge clk); #1;
            busy++;
        end
    endtask

    task automatic step(input logic [7:0] ch, output int busy, output int exp_busy);
        send(ch, busy);
        exp_busy = m_apply(ch);
    endtask

    task automatic goto_cell(input int row, input int col);
        int b, e;
        if (m_row > row) step(8'h0C, b, e);
        step(8'h0D, b, e);
        while (m_row < row) step(8'h0A, b, e);
        for (int i = 0; i < col; i++) step(8'($urandom_range(32, 126)), b, e);
    endtask

    task automatic wait_ready_after_reset(output int wr, output int bl);
        int w0 = n_wr, b0 = n_blank_wr, t = 0;
        while (!bus.o_ready && t < TMO) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (bus.o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_done_timeout: o_ready=%b required 1", bus.o_ready);
        end
        wr = n_wr - w0;
        bl = n_blank_wr - b0;
    endtask

    task automatic test_reset();
        int wr, bl;
        bus.i_valid = 1'b0;
        bus.i_char  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", bus.o_ready); end
        if (bus.o_vram_ce !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b want 0", bus.o_vram_ce); end
        if (bus.o_vram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.o_vram_we); end
        if (bus.o_vram_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", bus.o_vram_addr); end
        if (bus.o_vram_din !== 8'h00) begin n_fail++; $display("FAIL rst_din: got %0h want 0", bus.o_vram_din); end
        if (bus.o_row !== '0) begin n_fail++; $display("FAIL rst_row: got %0d want 0", bus.o_row); end
        if (bus.o_col !== '0) begin n_fail++; $display("FAIL rst_col: got %0d want 0", bus.o_col); end
        rst_n = 1'b1;
        wait_ready_after_reset(wr, bl);
        m_clear();
        m_row = 0;
        m_col = 0;
        n_checks += 3;
        if (wr !== CLR_CYC) begin n_fail++; $display("FAIL init_clr_writes: got %0d want %0d", wr, CLR_CYC); end
        if (bl !== CLR_CYC) begin n_fail++; $display("FAIL init_clr_blanks: got %0d want %0d", bl, CLR_CYC); end
        if (screen_diffs() !== 0) begin n_fail++; $display("FAIL init_clr_screen: %0d cells differ, want 0", screen_diffs()); end
    endtask

    task automatic test_first_char();
        int b, e, w0 = n_wr;
        step(8'h41, b, e);
        n_checks += 5;
        if (b !== 1) begin n_fail++; $display("FAIL first_busy: got %0d want 1", b); end
        if (vram[0] !== 8'h41) begin n_fail++; $display("FAIL first_data: got %0h want 41", vram[0]); end
        if (n_wr - w0 !== 1) begin n_fail++; $display("FAIL first_writes: got %0d want 1", n_wr - w0); end
        if (bus.o_row !== 5'd0) begin n_fail++; $display("FAIL first_row: got %0d want 0", bus.o_row); end
        if (bus.o_col !== 6'd1) begin n_fail++; $display("FAIL first_col: got %0d want 1", bus.o_col); end
    endtask

    task automatic test_random_mix();
        int b, e, sel;
        logic [7:0] ch;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: ch = 8'h0D;
                1: ch = 8'h08;
                2: ch = 8'h0A;
                3: ch = 8'($urandom_range(8'h0E, 8'h1F));
                4: ch = 8'($urandom_range(8'h7F, 8'hFF));
                default: ch = 8'($urandom_range(32, 126));
            endcase
            step(ch, b, e);
            n_checks += 3;
            if (b !== e) begin n_fail++; $display("FAIL mix_busy[%0d] ch=%0h: got %0d want %0d", i, ch, b, e); end
            if (int'(bus.o_row) !== m_row) begin n_fail++; $display("FAIL mix_row[%0d]: got %0d want %0d", i, bus.o_row, m_row); end
            if (int'(bus.o_col) !== m_col) begin n_fail++; $display("FAIL mix_col[%0d]: got %0d want %0d", i, bus.o_col, m_col); end
        end
        n_checks++;
        if (screen_diffs() !== 0) begin n_fail++; $display("FAIL mix_screen: %0d cells differ, want 0", screen_diffs()); end
    endtask

    task automatic test_wrap_no_scroll();
        int b, e, w0;
        goto_cell(5, COLS - 1);
        w0 = n_wr;
        step(8'h5A, b, e);
        n_checks += 5;
        if (b !== 1) begin n_fail++; $display("FAIL wrap_busy: got %0d want 1", b); end
        if (vram[addr_of(5, 59)] !== 8'h5A) begin n_fail++; $display("FAIL wrap_data: got %0h want 5a", vram[addr_of(5, 59)]); end
        if (n_wr - w0 !== 1) begin n_fail++; $display("FAIL wrap_writes: got %0d want 1", n_wr - w0); end
        if (bus.o_row !== 5'd6) begin n_fail++; $display("FAIL wrap_row: got %0d want 6", bus.o_row); end
        if (bus.o_col !== 6'd0) begin n_fail++; $display("FAIL wrap_col: got %0d want 0", bus.o_col); end
    endtask

    task automatic test_bs_cr();
        int b, e, a0;
        goto_cell(m_row, 0);
        a0 = n_acc;
        step(8'h08, b, e);
        n_checks += 3;
        if (bus.o_col !== 6'd0) begin n_fail++; $display("FAIL bs0_col: got %0d want 0", bus.o_col); end
        if (n_acc !== a0) begin n_fail++; $display("FAIL bs0_access: got %0d want 0", n_acc - a0); end
        if (b !== 0) begin n_fail++; $display("FAIL bs0_busy: got %0d want 0", b); end
        goto_cell(m_row, 30);
        a0 = n_acc;
        step(8'h0D, b, e);
        n_checks += 3;
        if (bus.o_col !== 6'd0) begin n_fail++; $display("FAIL cr_col: got %0d want 0", bus.o_col); end
        if (n_acc !== a0) begin n_fail++; $display("FAIL cr_access: got %0d want 0", n_acc - a0); end
        if (b !== 0) begin n_fail++; $display("FAIL cr_busy: got %0d want 0", b); end
        goto_cell(m_row, 12);
        step(8'h08, b, e);
        n_checks += 2;
        if (int'(bus.o_col) !== 11) begin n_fail++; $display("FAIL bs_col: got %0d want 11", bus.o_col); end
        if (screen_diffs() !== 0) begin n_fail++; $display("FAIL bs_no_erase: %0d cells differ, want 0", screen_diffs()); end
    endtask

    task automatic test_ignored();
        int b, e, a0, r0, c0;
        logic [7:0] codes [4];
        codes[0] = 8'h00; codes[1] = 8'h1B; codes[2] = 8'h7F; codes[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            a0 = n_acc; r0 = m_row; c0 = m_col;
            step(codes[i], b, e);
            n_checks += 3;
            if (n_acc !== a0) begin n_fail++; $display("FAIL ign_access[%0h]: got %0d want 0", codes[i], n_acc - a0); end
            if (int'(bus.o_row) !== r0 || int'(bus.o_col) !== c0) begin
                n_fail++; $display("FAIL ign_cursor[%0h]: got (%0d,%0d) want (%0d,%0d)", codes[i], bus.o_row, bus.o_col, r0, c0);
            end
            if (b !== 0) begin n_fail++; $display("FAIL ign_busy[%0h]: got %0d want 0", codes[i], b); end
        end
    endtask

    task automatic test_scroll_lf();
        int b, e, nb;
        goto_cell(ROWS - 1, COLS - 1);
        step(8'h0A, b, e);
        nb = 0;
        for (int c = 0; c < COLS; c++) if (vram[addr_of(ROWS - 1, c)] === BLANK) nb++;
        n_checks += 6;
        if (b !== SCROLL_CYC) begin n_fail++; $display("FAIL scroll_busy: got %0d want %0d", b, SCROLL_CYC); end
        if (screen_diffs() !== 0) begin n_fail++; $display("FAIL scroll_screen: %0d cells differ, want 0", screen_diffs()); end
        if (nb !== COLS) begin n_fail++; $display("FAIL scroll_last_blank: got %0d want %0d", nb, COLS); end
        if (int'(bus.o_row) !== ROWS - 1) begin n_fail++; $display("FAIL scroll_row: got %0d want %0d", bus.o_row, ROWS - 1); end
        if (int'(bus.o_col) !== COLS - 1) begin n_fail++; $display("FAIL scroll_col: got %0d want %0d", bus.o_col, COLS - 1); end
        if (n_illegal !== 0) begin n_fail++; $display("FAIL scroll_illegal_addr: got %0d want 0", n_illegal); end
    endtask

    task automatic test_wrap_scroll();
        int b, e;
        step(8'($urandom_range(33, 126)), b, e);
        n_checks += 4;
        if (b !== 1 + SCROLL_CYC) begin n_fail++; $display("FAIL wscroll_busy: got %0d want %0d", b, 1 + SCROLL_CYC); end
        if (screen_diffs() !== 0) begin n_fail++; $display("FAIL wscroll_screen: %0d cells differ, want 0", screen_diffs()); end
        if (int'(bus.o_row) !== ROWS - 1) begin n_fail++; $display("FAIL wscroll_row: got %0d want %0d", bus.o_row, ROWS - 1); end
        if (bus.o_col !== 6'd0) begin n_fail++; $display("FAIL wscroll_col: got %0d want 0", bus.o_col); end
    endtask

    task automatic test_ff_hold();
        int busy = 0, w0, b0, e, waitc = 0;
        goto_cell(9, 17);
        @(negedge clk);
        while (!bus.o_ready && waitc < TMO) begin @(negedge clk); waitc++; end
        w0 = n_wr; b0 = n_blank_wr;
        bus.i_valid = 1'b1;
        bus.i_char  = 8'h0C;
        @(posedge clk); #1;
        bus.i_char  = 8'h51;
        while (!bus.o_ready && busy < TMO) begin
            @(posedge clk); #1;
            busy++;
        end
        bus.i_valid = 1'b0;
        e = m_apply(8'h0C);
        n_checks += 6;
        if (busy !== e) begin n_fail++; $display("FAIL ff_busy: got %0d want %0d", busy, e); end
        if (n_wr - w0 !== CLR_CYC) begin n_fail++; $display("FAIL ff_writes: got %0d want %0d", n_wr - w0, CLR_CYC); end
        if (n_blank_wr - b0 !== CLR_CYC) begin n_fail++; $display("FAIL ff_blanks: got %0d want %0d", n_blank_wr - b0, CLR_CYC); end
        if (screen_diffs() !== 0) begin n_fail++; $display("FAIL ff_screen: %0d cells differ, want 0", screen_diffs()); end
        if (bus.o_row !== 5'd0) begin n_fail++; $display("FAIL ff_row: got %0d want 0", bus.o_row); end
        if (bus.o_col !== 6'd0) begin n_fail++; $display("FAIL ff_col: got %0d want 0", bus.o_col); end
    endtask

    task automatic test_reset_mid_scroll();
        int wr, bl, b, e;
        goto_cell(ROWS - 1, 20);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_char  = 8'h0A;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        repeat ($urandom_range(50, 1500)) @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        n_checks += 7;
        if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", bus.o_ready); end
        if (bus.o_vram_ce !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ce: got %b want 0", bus.o_vram_ce); end
        if (bus.o_vram_we !== 1'b0) begin n_fail++; $display("FAIL mid_rst_we: got %b want 0", bus.o_vram_we); end
        if (bus.o_vram_addr !== '0) begin n_fail++; $display("FAIL mid_rst_addr: got %0h want 0", bus.o_vram_addr); end
        if (bus.o_vram_din !== 8'h00) begin n_fail++; $display("FAIL mid_rst_din: got %0h want 0", bus.o_vram_din); end
        if (bus.o_row !== '0) begin n_fail++; $display("FAIL mid_rst_row: got %0d want 0", bus.o_row); end
        if (bus.o_col !== '0) begin n_fail++; $display("FAIL mid_rst_col: got %0d want 0", bus.o_col); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready_after_reset(wr, bl);
        m_clear();
        m_row = 0;
        m_col = 0;
        n_checks += 2;
        if (wr !== CLR_CYC) begin n_fail++; $display("FAIL mid_clr_writes: got %0d want %0d", wr, CLR_CYC); end
        if (screen_diffs() !== 0) begin n_fail++; $display("FAIL mid_clr_screen: %0d cells differ, want 0", screen_diffs()); end
        step(8'h42, b, e);
        n_checks += 2;
        if (vram[0] !== 8'h42) begin n_fail++; $display("FAIL post_rst_char: got %0h want 42", vram[0]); end
        if (n_illegal !== 0) begin n_fail++; $display("FAIL illegal_addr: got %0d want 0", n_illegal); end
    endtask

    initial begin
        test_reset();
        test_first_char();
        test_random_mix();
        test_wrap_no_scroll();
        test_bs_cr();
        test_ignored();
        test_scroll_lf();
        test_wrap_scroll();
        test_ff_hold();
        test_reset_mid_scroll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
